cpu: RTL and testbench

- 32-bit multicycle load/store processor core with 32 general registers and separate instruction and data memory ports.
- Each port uses a level request / done handshake.
- Sits between a word-addressed instruction RAM and a data bus; the data bus is decoded by the integrator (address bit 31 = 1 selects memory-mapped I/O that acknowledges combinationally).
- Companion memories are 1-cycle-latency synchronous RAMs.

---
 rtl/cpu.sv | 120 ++++++++++++
 tb/tb_cpu.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: 32-bit multicycle load/store core with FETCH/EXEC/MEM request-done handshakes
module cpu #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] Instruktion,
   input  logic        InstruktionGeladen,
   input  logic [31:0] DatenRein,
   input  logic        DatenGeladen,
   input  logic        DatenGespeichert,
   output logic [31:0] InstruktionAdresse,
   output logic        LeseInstruktion,
   output logic [31:0] DatenAdresse,
   output logic [31:0] DatenRaus,
   output logic        LeseDaten,
   output logic        SchreibeDaten
);
   typedef enum logic [1:0] {FETCH, EXEC, MEM} stateT;
   stateT state, stateNext;
   logic [31:0] pc, pcNext, ir;
   logic [31:0] regs [32];
   logic [5:0] op;
   logic [4:0] rd, rs1, rs2;
   logic [10:0] f;
   logic [31:0] a, b, immS, aluRes, wData;
   logic aluOk, isLoad, isStore, isMem, wEn, memDone, inMem;

   assign op = ir[31:26];
   assign rd = ir[25:21];
   assign rs1 = ir[20:16];
   assign rs2 = ir[15:11];
   assign immS = {{16{ir[15]}}, ir[15:0]};
   assign a = regs[rs1];
   assign f = (op == 6'd0) ? ir[10:0] : {8'd0, op[2:0]};
   assign b = (op == 6'd0) ? regs[rs2] : (op[2:1] == 2'b00) ? immS : {16'd0, ir[15:0]};
   assign isLoad = op == 6'h2B;
   assign isStore = op == 6'h2C;
   assign isMem = isLoad || isStore;
   assign memDone = isLoad ? DatenGeladen : DatenGespeichert;
   assign inMem = !Reset && state == MEM;

   assign LeseInstruktion = !Reset && state == FETCH;
   assign InstruktionAdresse = pc;
   assign LeseDaten = inMem && isLoad;
   assign SchreibeDaten = inMem && isStore;
   assign DatenAdresse = inMem ? a + immS : 32'd0;
   assign DatenRaus = inMem ? regs[rd] : 32'd0;

   // ALU shared by R-type and I-type; undefined functions flag aluOk low so they act as NOP
   always_comb begin
      aluRes = 32'd0;
      aluOk = (op == 6'd0) || (op[5:3] == 3'b100);
      case (f)
         11'h000: aluRes = a + b;
         11'h001: aluRes = a - b;
         11'h002: aluRes = a & b;
         11'h003: aluRes = a | b;
         11'h004: aluRes = a ^ b;
         11'h005: aluRes = $signed(a) >>> b[4:0];
         11'h006: aluRes = a << b[4:0];
         11'h007: aluRes = a >> b[4:0];
         11'h010: aluRes = {31'd0, a == b};
         11'h011: aluRes = {31'd0, a != b};
         11'h012: aluRes = {31'd0, $signed(a) < $signed(b)};
         default: aluOk = 1'b0;
      endcase
   end

   // next state, next PC and register write selection
   always_comb begin
      stateNext = state;
      pcNext = pc;
      wEn = 1'b0;
      wData = aluRes;
      case (state)
         FETCH: stateNext = InstruktionGeladen ? EXEC : FETCH;
         EXEC: begin
            stateNext = isMem ? MEM : FETCH;
            wEn = aluOk;
            pcNext = isMem ? pc : pc + 32'd1;
            if ((op == 6'h2E && a == 32'd0) || (op == 6'h2F && a != 32'd0))
               pcNext = pc + 32'd1 + immS;
            if (op == 6'h10)
               pcNext = pc + 32'd1 + {{6{ir[25]}}, ir[25:0]};
         end
         MEM: if (memDone) begin
            stateNext = FETCH;
            pcNext = pc + 32'd1;
            wEn = isLoad;
            wData = DatenRein;
         end
         default: stateNext = FETCH;
      endcase
   end

   // state, PC and instruction latch
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= FETCH;
         pc <= RESET_PC;
         ir <= 32'd0;
      end else begin
         state <= stateNext;
         pc <= pcNext;
         if (state == FETCH && InstruktionGeladen)
            ir <= Instruktion;
      end
   end

   // register file; R0 is never written so it always reads 0
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= 32'd0;
      end else if (wEn && rd != 5'd0) begin
         regs[rd] <= wData;
      end
   end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs plus random programs checked against an ISA-level model
module tb_cpu;
   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] Instruktion;
   logic        InstruktionGeladen;
   logic [31:0] DatenRein;
   logic        DatenGeladen;
   logic        DatenGespeichert;
   logic [31:0] InstruktionAdresse;
   logic        LeseInstruktion;
   logic [31:0] DatenAdresse;
   logic [31:0] DatenRaus;
   logic        LeseDaten;
   logic        SchreibeDaten;

   cpu dut (
      .Clock(Clock), .Reset(Reset),
      .Instruktion(Instruktion), .InstruktionGeladen(InstruktionGeladen),
      .DatenRein(DatenRein), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
      .InstruktionAdresse(InstruktionAdresse), .LeseInstruktion(LeseInstruktion),
      .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus),
      .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten)
   );

   always #5 Clock = ~Clock;

   logic [31:0] imem [256];
   logic [31:0] dmem [256];
   logic        clrMem = 1'b0;
   logic        ramRd, ramWr;
   logic [31:0] ramData;
   int vectors = 0;
   int miscompares = 0;
   int wrHigh = 0, rdHigh = 0, bad = 0;
   bit prevDone = 0, prevWait = 0, prevIDone = 0;
   logic [31:0] gotA [$];
   logic [31:0] gotD [$];
   logic [31:0] expA [$];
   logic [31:0] expD [$];

   assign DatenRein = ramData;
   assign DatenGeladen = ramRd | (LeseDaten & DatenAdresse[31]);
   assign DatenGespeichert = ramWr | (SchreibeDaten & DatenAdresse[31]);

   // 1-cycle-latency instruction and data RAMs
   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         InstruktionGeladen <= 1'b0;
         ramRd <= 1'b0;
         ramWr <= 1'b0;
      end else begin
         InstruktionGeladen <= LeseInstruktion;
         ramRd <= LeseDaten & !DatenAdresse[31];
         ramWr <= SchreibeDaten & !DatenAdresse[31];
      end
   end

   always @(posedge Clock) begin
      Instruktion <= imem[InstruktionAdresse[7:0]];
      ramData <= dmem[DatenAdresse[7:0]];
      if (clrMem) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
      end else if (SchreibeDaten && !DatenAdresse[31]) begin
         dmem[DatenAdresse[7:0]] <= DatenRaus;
      end
   end

   // handshake monitor and I/O store log
   always @(posedge Clock) begin
      if (Reset) begin
         prevDone = 0; prevWait = 0; prevIDone = 0;
      end else begin
         if (SchreibeDaten && !DatenAdresse[31]) wrHigh++;
         if (LeseDaten && !DatenAdresse[31]) rdHigh++;
         if (prevDone && (LeseDaten || SchreibeDaten)) bad++;
         if (prevWait && !(LeseDaten || SchreibeDaten)) bad++;
         if (prevIDone && LeseInstruktion) bad++;
         if (SchreibeDaten && DatenAdresse[31] && DatenGespeichert) begin
            gotA.push_back(DatenAdresse);
            gotD.push_back(DatenRaus);
         end
         prevDone = (LeseDaten && DatenGeladen) || (SchreibeDaten && DatenGespeichert);
         prevWait = (LeseDaten && !DatenGeladen) || (SchreibeDaten && !DatenGespeichert);
         prevIDone = LeseInstruktion && InstruktionGeladen;
      end
   end

   function automatic logic [31:0] rI(input int fn, input int d, input int s1, input int s2);
      return {6'd0, 5'(d), 5'(s1), 5'(s2), 11'(fn)};
   endfunction

   function automatic logic [31:0] iI(input int o, input int d, input int s1, input int imm);
      return {6'(o), 5'(d), 5'(s1), 16'(imm)};
   endfunction

   function automatic logic [31:0] jmp(input int off);
      return {6'h10, 26'(off)};
   endfunction

   function automatic logic [32:0] aluRef(input int fn, input logic [31:0] x, input logic [31:0] y);
      int sh;
      sh = int'(y[4:0]);
      case (fn)
         0: return {1'b1, x + y};
         1: return {1'b1, x - y};
         2: return {1'b1, x & y};
         3: return {1'b1, x | y};
         4: return {1'b1, x ^ y};
         5: return {1'b1, 32'($signed(x) >>> sh)};
         6: return {1'b1, x << sh};
         7: return {1'b1, x >> sh};
         'h10: return {1'b1, (x == y) ? 32'd1 : 32'd0};
         'h11: return {1'b1, (x != y) ? 32'd1 : 32'd0};
         'h12: return {1'b1, ($signed(x) < $signed(y)) ? 32'd1 : 32'd0};
         default: return 33'd0;
      endcase
   endfunction

   // instruction-level interpreter of the program in imem, collecting expected I/O stores
   task automatic modelRun(input logic [31:0] haltPc);
      logic [31:0] r [32];
      logic [31:0] m [256];
      logic [31:0] pc, ins, sx, ad, y, nxt;
      logic [32:0] res;
      logic [5:0] o;
      int d, s1, s2;
      for (int i = 0; i < 32; i++) r[i] = 0;
      for (int i = 0; i < 256; i++) m[i] = 0;
      expA.delete();
      expD.delete();
      pc = 0;
      for (int s = 0; s < 5000 && pc != haltPc; s++) begin
         ins = imem[pc[7:0]];
         o = ins[31:26];
         d = int'(ins[25:21]);
         s1 = int'(ins[20:16]);
         s2 = int'(ins[15:11]);
         sx = {{16{ins[15]}}, ins[15:0]};
         nxt = pc + 1;
         if (o == 6'd0 || o[5:3] == 3'b100) begin
            y = (o == 6'd0) ? r[s2] : (o[2:0] <= 3'd1) ? sx : {16'd0, ins[15:0]};
            res = aluRef((o == 6'd0) ? int'(ins[10:0]) : int'(o[2:0]), r[s1], y);
            if (res[32] && d != 0) r[d] = res[31:0];
         end else if (o == 6'h2B) begin
            ad = r[s1] + sx;
            if (d != 0) r[d] = m[ad[7:0]];
         end else if (o == 6'h2C) begin
            ad = r[s1] + sx;
            if (ad[31]) begin
               expA.push_back(ad);
               expD.push_back(r[d]);
            end else m[ad[7:0]] = r[d];
         end else if ((o == 6'h2E && r[s1] == 0) || (o == 6'h2F && r[s1] != 0)) begin
            nxt = pc + 1 + sx;
         end else if (o == 6'h10) begin
            nxt = pc + 1 + {{6{ins[25]}}, ins[25:0]};
         end
         pc = nxt;
      end
   endtask

   task automatic fillImem();
      for (int i = 0; i < 256; i++) imem[i] = jmp(-1);
   endtask

   task automatic doReset();
      @(negedge Clock);
      Reset = 1'b1;
      clrMem = 1'b1;
      repeat (2) @(negedge Clock);
      clrMem = 1'b0;
      Reset = 1'b0;
   endtask

   task automatic waitHalt(input logic [31:0] haltPc, input int budget, output bit ok);
      ok = 0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge Clock);
         if (LeseInstruktion && InstruktionAdresse == haltPc) ok = 1;
      end
   endtask

   task automatic test_reset();
      int n;
      fillImem();
      imem[0] = iI('h20, 1, 0, 1);
      @(negedge Clock);
      Reset = 1'b1;
      repeat (10) @(negedge Clock);
      vectors++;
      if ({LeseInstruktion, LeseDaten, SchreibeDaten} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_requests got=%b want=000", {LeseInstruktion, LeseDaten, SchreibeDaten});
      end
      vectors++;
      if (InstruktionAdresse !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_pc got=%h want=0", InstruktionAdresse);
      end
      vectors++;
      if ({DatenAdresse, DatenRaus} !== 64'd0) begin
         miscompares++;
         $display("FAIL reset_data got=%h/%h want=0/0", DatenAdresse, DatenRaus);
      end
      Reset = 1'b0;
      #1;
      vectors++;
      if (LeseInstruktion !== 1'b1 || InstruktionAdresse !== 32'd0) begin
         miscompares++;
         $display("FAIL release_fetch got=%b@%h want=1@0", LeseInstruktion, InstruktionAdresse);
      end
      n = 0;
      while (InstruktionAdresse !== 32'd1 && n < 20) begin
         @(negedge Clock);
         n++;
      end
      vectors++;
      if (n != 3) begin
         miscompares++;
         $display("FAIL alu_cycles got=%0d want=3", n);
      end
   endtask

   task automatic test_loop();
      int base;
      bit ok;
      logic [31:0] sum;
      fillImem();
      imem[0] = 32'h8040000F;
      imem[1] = iI('h20, 31, 0, 1);
      imem[2] = iI('h26, 31, 31, 31);
      imem[3] = rI(0, 1, 1, 2);
      imem[4] = iI('h21, 2, 2, 1);
      imem[5] = rI('h10, 3, 2, 0);
      imem[6] = iI('h2C, 1, 31, 0);
      imem[7] = iI('h2E, 0, 3, -5);
      imem[8] = iI('h2C, 3, 31, 1);
      imem[9] = 32'h43FFFFFF;
      base = gotA.size();
      doReset();
      waitHalt(32'd9, 2000, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL loop_halt got=timeout want=pc9");
      end
      vectors++;
      if (gotA.size() - base != 16) begin
         miscompares++;
         $display("FAIL loop_store_count got=%0d want=16", gotA.size() - base);
      end
      sum = 0;
      for (int i = 0; i < 15 && base + i < gotA.size(); i++) begin
         sum += 32'(15 - i);
         vectors++;
         if ({gotA[base+i], gotD[base+i]} !== {32'h80000000, sum}) begin
            miscompares++;
            $display("FAIL loop_store%0d got=%h:%h want=80000000:%h", i, gotA[base+i], gotD[base+i], sum);
         end
      end
      if (gotA.size() > base + 15) begin
         vectors++;
         if ({gotA[base+15], gotD[base+15]} !== {32'h80000001, 32'd1}) begin
            miscompares++;
            $display("FAIL loop_flag got=%h:%h want=80000001:1", gotA[base+15], gotD[base+15]);
         end
      end
      repeat (5) @(negedge Clock);
      waitHalt(32'd9, 10, ok);
      vectors++;
      if (!ok || gotA.size() - base != 16) begin
         miscompares++;
         $display("FAIL self_loop got=ok%0d/%0d stores want=ok1/16", ok, gotA.size() - base);
      end
   endtask

   task automatic test_ram();
      int base, w0, r0, b0;
      bit ok;
      fillImem();
      imem[0] = iI('h20, 9, 0, 'h1234);
      imem[1] = iI('h2C, 9, 0, 5);
      imem[2] = iI('h2B, 4, 0, 5);
      imem[3] = iI('h2C, 4, 0, 'h8000);
      imem[4] = jmp(-1);
      base = gotA.size();
      w0 = wrHigh; r0 = rdHigh; b0 = bad;
      doReset();
      waitHalt(32'd4, 200, ok);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL ram_halt got=timeout want=pc4");
      end
      vectors++;
      if (wrHigh - w0 != 2 || rdHigh - r0 != 2) begin
         miscompares++;
         $display("FAIL ram_req_cycles got=wr%0d/rd%0d want=2/2", wrHigh - w0, rdHigh - r0);
      end
      vectors++;
      if (bad != b0) begin
         miscompares++;
         $display("FAIL handshake got=%0d violations want=0", bad - b0);
      end
      vectors++;
      if (dmem[5] !== 32'h1234) begin
         miscompares++;
         $display("FAIL ram_word got=%h want=1234", dmem[5]);
      end
      vectors++;
      if (gotA.size() != base + 1 || gotA[gotA.size()-1] !== 32'hFFFF8000 || gotD[gotD.size()-1] !== 32'h1234) begin
         miscompares++;
         $display("FAIL load_back got=%0d stores last=%h want=1 stores 1234", gotA.size() - base, gotD[gotD.size()-1]);
      end
   endtask

   task automatic test_alu_edge();
      int base;
      bit ok;
      logic [31:0] want [5];
      want = '{32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd0};
      fillImem();
      imem[0] = iI('h20, 1, 0, 1);
      imem[1] = rI(1, 5, 0, 1);
      imem[2] = rI('h12, 6, 5, 0);
      imem[3] = iI('h20, 10, 0, 31);
      imem[4] = rI(7, 7, 5, 10);
      imem[5] = rI(5, 11, 5, 10);
      imem[6] = iI('h20, 0, 0, 7);
      imem[7] = rI(0, 8, 0, 0);
      imem[8] = iI('h2C, 5, 0, 'h8000);
      imem[9] = iI('h2C, 6, 0, 'h8001);
      imem[10] = iI('h2C, 7, 0, 'h8002);
      imem[11] = iI('h2C, 11, 0, 'h8003);
      imem[12] = iI('h2C, 8, 0, 'h8004);
      imem[13] = jmp(-1);
      base = gotA.size();
      doReset();
      waitHalt(32'd13, 300, ok);
      vectors++;
      if (!ok || gotA.size() != base + 5) begin
         miscompares++;
         $display("FAIL edge_run got=ok%0d/%0d stores want=ok1/5", ok, gotA.size() - base);
      end
      for (int k = 0; k < 5 && base + k < gotA.size(); k++) begin
         vectors++;
         if ({gotA[base+k], gotD[base+k]} !== {32'hFFFF8000 + 32'(k), want[k]}) begin
            miscompares++;
            $display("FAIL edge%0d got=%h:%h want=%h:%h", k, gotA[base+k], gotD[base+k], 32'hFFFF8000 + 32'(k), want[k]);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      int n;
      n = 0;
      @(negedge Clock);
      while (!LeseInstruktion && n < 10) begin
         @(negedge Clock);
         n++;
      end
      vectors++;
      if (LeseInstruktion !== 1'b1 || InstruktionAdresse !== 32'd13) begin
         miscompares++;
         $display("FAIL pre_abort got=%b@%h want=1@0000000d", LeseInstruktion, InstruktionAdresse);
      end
      #2 Reset = 1'b1;
      #1;
      vectors++;
      if ({LeseInstruktion, LeseDaten, SchreibeDaten} !== 3'b000 || InstruktionAdresse !== 32'd0) begin
         miscompares++;
         $display("FAIL abort got=%b@%h want=000@0", {LeseInstruktion, LeseDaten, SchreibeDaten}, InstruktionAdresse);
      end
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      #1;
      vectors++;
      if (LeseInstruktion !== 1'b1 || InstruktionAdresse !== 32'd0) begin
         miscompares++;
         $display("FAIL abort_release got=%b@%h want=1@0", LeseInstruktion, InstruktionAdresse);
      end
   endtask

   task automatic test_random();
      int fnList [14];
      int L, base, off, kind, haltPc;
      logic [5:0] undef [3];
      bit ok;
      fnList = '{0, 1, 2, 3, 4, 5, 6, 7, 'h10, 'h11, 'h12, 8, 'h13, 'h7FF};
      undef = '{6'h01, 6'h28, 6'h3F};
      L = 30;
      haltPc = L + 31;
      for (int p = 0; p < 20; p++) begin
         fillImem();
         for (int i = 0; i < L; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3)
               imem[i] = rI(fnList[$urandom_range(0, 13)], int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
            else if (kind <= 6)
               imem[i] = iI('h20 + int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)));
            else if (kind == 7)
               imem[i] = iI($urandom_range(0, 1) ? 'h2B : 'h2C, int'($urandom_range(0, 31)), 0, int'($urandom_range(0, 15)));
            else if (kind == 8) begin
               off = int'($urandom_range(0, 2));
               if (off > L - 1 - i) off = L - 1 - i;
               imem[i] = iI($urandom_range(0, 1) ? 'h2E : 'h2F, 0, int'($urandom_range(0, 31)), off);
            end else
               imem[i] = {undef[$urandom_range(0, 2)], 26'($urandom)};
         end
         for (int k = 1; k < 32; k++) imem[L + k - 1] = iI('h2C, k, 0, 'h8000 + k);
         imem[haltPc] = jmp(-1);
         modelRun(32'(haltPc));
         base = gotA.size();
         doReset();
         waitHalt(32'(haltPc), 3000, ok);
         vectors++;
         if (!ok || gotA.size() - base != expA.size()) begin
            miscompares++;
            $display("FAIL rand%0d_run got=ok%0d/%0d stores want=ok1/%0d", p, ok, gotA.size() - base, expA.size());
         end
         for (int k = 0; k < expA.size() && base + k < gotA.size(); k++) begin
            vectors++;
            if ({gotA[base+k], gotD[base+k]} !== {expA[k], expD[k]}) begin
               miscompares++;
               $display("FAIL rand%0d_store%0d got=%h:%h want=%h:%h", p, k, gotA[base+k], gotD[base+k], expA[k], expD[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_loop();
      test_ram();
      test_alu_edge();
      test_reset_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
